// File: rtl/ttlc_dbg_pkg.sv
// ttlc_dbg_pkg
// Shared definitions for the TTLC run-control block on debug page 0x4:
//   - run-state encodings (HALTED/RUN/STEP)
//   - CTRL command bits and REASON bit positions
//   - register offsets within the page, and the default page number
//   - a lowest-set-bit priority helper used by the breakpoint matcher
package ttlc_dbg_pkg;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } run_state_e;

  // CTRL write command bits
  localparam int CTRL_RUN  = 0;
  localparam int CTRL_STEP = 1;
  localparam int CTRL_HALT = 2;

  // REASON sticky bit positions
  localparam int RSN_MANUAL = 0;
  localparam int RSN_BRK    = 1;
  localparam int RSN_STEP   = 2;

  // Register offsets (dbg_a[3:0])
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PC     = 4'h1;
  localparam logic [3:0] OFF_STEPN  = 4'h2;
  localparam logic [3:0] OFF_REASON = 4'h3;
  localparam logic [3:0] OFF_BRK_EN = 4'h4;
  localparam logic [3:0] OFF_HITCNT = 4'h5;
  localparam logic [3:0] OFF_BRK0   = 4'h8;

  localparam logic [3:0] DBG_PAGE = 4'h4;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [2:0] lowest_idx8(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = v[i] ? 3'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ttlc_brk_match.sv
// ttlc_brk_match
// NUM_BRK parallel PC comparators with per-comparator enable and a global
// skip gate; reports whether any enabled comparator matches and the lowest
// matching index.
// Ports:
//   i_pc    current core PC
//   i_addr  breakpoint addresses, one per comparator
//   i_en    enable mask
//   i_skip  suppresses all matches while set
//   o_hit   any enabled, unskipped comparator matches
//   o_idx   lowest matching comparator index (0 when no hit)
module ttlc_brk_match
  import ttlc_dbg_pkg::*;
#(
  parameter int NUM_BRK  = 4,
  parameter int PC_WIDTH = 12
) (
  input  logic [PC_WIDTH-1:0]              i_pc,
  input  logic [NUM_BRK-1:0][PC_WIDTH-1:0] i_addr,
  input  logic [NUM_BRK-1:0]               i_en,
  input  logic                             i_skip,
  output logic                             o_hit,
  output logic [2:0]                       o_idx
);

  logic [NUM_BRK-1:0] w_match;

  // Per-comparator match, gated by enable and skip.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_BRK; i++) begin
      w_match[i] = i_en[i] && !i_skip && (i_addr[i] == i_pc);
    end
  end

  assign o_hit = |w_match;
  assign o_idx = lowest_idx8(8'(w_match));

endmodule

// File: rtl/ttlc_run_ctrl.sv
// ttlc_run_ctrl
// Run-control and breakpoint unit for the TTLC core, decoded on debug page
// PAGE. Provides RUN / multi-instruction STEP / manual HALT commands,
// NUM_BRK maskable PC breakpoints and a sticky halt-reason register.
// Optional feature macro: TTLC_BRK_HITCNT_EN adds a 16-bit saturating
// breakpoint-halt counter at offset 5 (reads 0 when not defined).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   dbg_a/di/we/rd  debug bus address, write data, write strobe, read strobe
//   dbg_do          read data (0 unless page selected and dbg_rd)
//   dbg_ready       page selected and access in progress; never stalls
//   core_pc         PC of the instruction about to retire
//   core_i_ready    one-cycle pulse per retired instruction
//   core_status     core status bits shown in CTRL readback
//   core_halt       registered halt to the core
//   halt_evt        one-cycle pulse on every entry to HALTED
module ttlc_run_ctrl
  import ttlc_dbg_pkg::*;
#(
  parameter int         NUM_BRK  = 4,
  parameter int         PC_WIDTH = 12,
  parameter int         STEP_W   = 8,
  parameter logic [3:0] PAGE     = DBG_PAGE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          dbg_a,
  input  logic [15:0]         dbg_di,
  output logic [15:0]         dbg_do,
  input  logic                dbg_we,
  input  logic                dbg_rd,
  output logic                dbg_ready,
  input  logic [PC_WIDTH-1:0] core_pc,
  input  logic                core_i_ready,
  input  logic [2:0]          core_status,
  output logic                core_halt,
  output logic                halt_evt
);

  logic                              w_sel;
  logic                              w_wr;
  logic [3:0]                        w_off;
  logic                              w_ctrl_wr;
  logic                              w_halt_req;

  run_state_e                        r_state;
  run_state_e                        w_state_nxt;
  logic                              r_core_halt;
  logic                              r_halt_evt;
  logic                              r_skip;
  logic [STEP_W-1:0]                 r_stepn;
  logic [STEP_W-1:0]                 r_step_cnt;
  logic [2:0]                        r_rsn_bits;
  logic [2:0]                        r_rsn_idx;
  logic [2:0]                        w_rsn_bits_nxt;
  logic [2:0]                        w_rsn_idx_nxt;
  logic [2:0]                        w_rsn_clr;
  logic [NUM_BRK-1:0]                r_brk_en;
  logic [NUM_BRK-1:0][PC_WIDTH-1:0]  r_brk_addr;

  logic                              w_brk_hit;
  logic [2:0]                        w_brk_idx;
  logic                              w_set_man;
  logic                              w_set_brk;
  logic                              w_set_step;
  logic                              w_load_cnt;
  logic                              w_dec_cnt;
  logic                              w_leave_halt;
  logic [15:0]                       w_hitcnt;
  logic [15:0]                       w_rdata;
  logic                              w_unused_ok;

  assign w_sel      = (dbg_a[7:4] == PAGE);
  assign w_off      = dbg_a[3:0];
  assign w_wr       = w_sel && dbg_we;
  assign w_ctrl_wr  = w_wr && (w_off == OFF_CTRL);
  assign w_halt_req = w_ctrl_wr && dbg_di[CTRL_HALT];
  assign w_unused_ok = ^dbg_di;

  ttlc_brk_match #(
    .NUM_BRK  (NUM_BRK),
    .PC_WIDTH (PC_WIDTH)
  ) u_brk_match (
    .i_pc   (core_pc),
    .i_addr (r_brk_addr),
    .i_en   (r_brk_en),
    .i_skip (r_skip),
    .o_hit  (w_brk_hit),
    .o_idx  (w_brk_idx)
  );

  // Run-state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_HALTED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and halt cause. Manual HALT beats breakpoint beats step-done;
  // breakpoints are not considered while stepping.
  always_comb begin
    w_state_nxt = r_state;
    w_set_man   = 1'b0;
    w_set_brk   = 1'b0;
    w_set_step  = 1'b0;
    w_load_cnt  = 1'b0;
    w_dec_cnt   = 1'b0;
    case (r_state)
      ST_HALTED: begin
        if (w_ctrl_wr && dbg_di[CTRL_STEP]) begin
          w_state_nxt = ST_STEP;
          w_load_cnt  = 1'b1;
        end else if (w_ctrl_wr && dbg_di[CTRL_RUN]) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_RUN: begin
        if (w_halt_req) begin
          w_state_nxt = ST_HALTED;
          w_set_man   = 1'b1;
        end else if (w_brk_hit) begin
          w_state_nxt = ST_HALTED;
          w_set_brk   = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_STEP: begin
        if (w_halt_req) begin
          w_state_nxt = ST_HALTED;
          w_set_man   = 1'b1;
        end else if (core_i_ready && (r_step_cnt == STEP_W'(1))) begin
          w_state_nxt = ST_HALTED;
          w_set_step  = 1'b1;
        end else if (core_i_ready) begin
          w_state_nxt = ST_STEP;
          w_dec_cnt   = 1'b1;
        end else begin
          w_state_nxt = ST_STEP;
        end
      end
      default: begin
        w_state_nxt = ST_HALTED;
      end
    endcase
  end

  assign w_leave_halt = (r_state == ST_HALTED) && (w_state_nxt != ST_HALTED);

  // Halt output and entry pulse, both aligned to the registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_core_halt <= 1'b1;
      r_halt_evt  <= 1'b0;
    end else begin
      r_core_halt <= (w_state_nxt == ST_HALTED);
      r_halt_evt  <= (r_state != ST_HALTED) && (w_state_nxt == ST_HALTED);
    end
  end

  // Skip is raised on leaving HALTED so the PC we halted at cannot re-trigger;
  // it drops with the first retirement after that.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skip <= 1'b0;
    end else if (w_leave_halt) begin
      r_skip <= 1'b1;
    end else if (core_i_ready) begin
      r_skip <= 1'b0;
    end else begin
      r_skip <= r_skip;
    end
  end

  // Step counter: loaded with max(STEPN,1), zero only while HALTED.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_cnt <= '0;
    end else if (w_load_cnt) begin
      r_step_cnt <= (r_stepn == '0) ? STEP_W'(1) : r_stepn;
    end else if (w_state_nxt == ST_HALTED) begin
      r_step_cnt <= '0;
    end else if (w_dec_cnt) begin
      r_step_cnt <= r_step_cnt - STEP_W'(1);
    end else begin
      r_step_cnt <= r_step_cnt;
    end
  end

  // REASON next value: write-1-to-clear first, then any new cause, so a
  // same-cycle set survives the clear.
  always_comb begin
    w_rsn_clr      = (w_wr && (w_off == OFF_REASON)) ? dbg_di[2:0] : 3'b000;
    w_rsn_bits_nxt = (r_rsn_bits & ~w_rsn_clr) | {w_set_step, w_set_brk, w_set_man};
    if (w_set_brk) begin
      w_rsn_idx_nxt = w_brk_idx;
    end else if (w_rsn_clr[RSN_BRK]) begin
      w_rsn_idx_nxt = 3'd0;
    end else begin
      w_rsn_idx_nxt = r_rsn_idx;
    end
  end

  // Software-visible configuration and sticky reason registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stepn    <= '0;
      r_brk_en   <= '0;
      r_rsn_bits <= 3'b000;
      r_rsn_idx  <= 3'd0;
    end else begin
      r_stepn    <= (w_wr && (w_off == OFF_STEPN))  ? dbg_di[STEP_W-1:0]  : r_stepn;
      r_brk_en   <= (w_wr && (w_off == OFF_BRK_EN)) ? dbg_di[NUM_BRK-1:0] : r_brk_en;
      r_rsn_bits <= w_rsn_bits_nxt;
      r_rsn_idx  <= w_rsn_idx_nxt;
    end
  end

  // Breakpoint address registers at offsets 8..8+NUM_BRK-1.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BRK; i++) begin
      if (rst) begin
        r_brk_addr[i] <= '0;
      end else if (w_wr && (w_off == (OFF_BRK0 + 4'(i)))) begin
        r_brk_addr[i] <= dbg_di[PC_WIDTH-1:0];
      end else begin
        r_brk_addr[i] <= r_brk_addr[i];
      end
    end
  end

`ifdef TTLC_BRK_HITCNT_EN
  logic [15:0] r_hitcnt;

  // Saturating count of breakpoint halts; a write to its offset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hitcnt <= 16'h0000;
    end else if (w_wr && (w_off == OFF_HITCNT)) begin
      r_hitcnt <= 16'h0000;
    end else if (w_set_brk && (r_hitcnt != 16'hFFFF)) begin
      r_hitcnt <= r_hitcnt + 16'h0001;
    end else begin
      r_hitcnt <= r_hitcnt;
    end
  end

  assign w_hitcnt = r_hitcnt;
`else
  assign w_hitcnt = 16'h0000;
`endif

  // Register readback mux.
  always_comb begin
    w_rdata = 16'h0000;
    case (w_off)
      OFF_CTRL:   w_rdata = {8'h00, core_status, |r_rsn_bits, 2'b00, r_state};
      OFF_PC:     w_rdata = 16'(core_pc);
      OFF_STEPN:  w_rdata = 16'(r_stepn);
      OFF_REASON: w_rdata = {9'h000, r_rsn_idx, 1'b0, r_rsn_bits};
      OFF_BRK_EN: w_rdata = 16'(r_brk_en);
      OFF_HITCNT: w_rdata = w_hitcnt;
      default: begin
        w_rdata = 16'h0000;
        for (int i = 0; i < NUM_BRK; i++) begin
          w_rdata = (w_off == (OFF_BRK0 + 4'(i))) ? 16'(r_brk_addr[i]) : w_rdata;
        end
      end
    endcase
  end

  assign dbg_do    = (w_sel && dbg_rd) ? w_rdata : 16'h0000;
  assign dbg_ready = w_sel && (dbg_rd || dbg_we);
  assign core_halt = r_core_halt;
  assign halt_evt  = r_halt_evt;

endmodule
